// File: rtl/decoder_scan.sv
// One-hot decoder with direct-decode and auto-scan modes, all outputs registered.
// Optional feature: define DECODER_SCAN_DIR_EN to add the dir input (scan down when dir=1).
module decoder_scan #(
    parameter int unsigned SEL_W   = 3,
    parameter int unsigned DWELL_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  e,
    input  logic                  mode,
    input  logic [SEL_W-1:0]      sel,
    input  logic                  load,
    input  logic [DWELL_W-1:0]    dwell,
`ifdef DECODER_SCAN_DIR_EN
    input  logic                  dir,
`endif
    output logic [(2**SEL_W)-1:0] d,
    output logic [SEL_W-1:0]      idx,
    output logic                  wrap
);

    localparam int unsigned OUT_W = 2 ** SEL_W;

    typedef enum logic [1:0] {
        BLANK  = 2'd0,
        DIRECT = 2'd1,
        SCAN   = 2'd2
    } ctrl_e;

    ctrl_e               ctrl_c;
    logic [OUT_W-1:0]    d_q, d_d;
    logic [SEL_W-1:0]    idx_q, idx_d;
    logic [DWELL_W-1:0]  cnt_q, cnt_d;
    logic                wrap_q, wrap_d;
    logic                down_c;
    logic [SEL_W-1:0]    step_idx_c;
    logic                step_wraps_c;

    // Control state is a pure function of the current inputs.
    always_comb begin
        ctrl_c = BLANK;
        if (e) begin
            ctrl_c = mode ? SCAN : DIRECT;
        end
    end

`ifdef DECODER_SCAN_DIR_EN
    assign down_c = dir;
`else
    assign down_c = 1'b0;
`endif

    // Next scan index and whether that step crosses the end of the range.
    always_comb begin
        step_idx_c   = idx_q + SEL_W'(1);
        step_wraps_c = (idx_q == {SEL_W{1'b1}});
        if (down_c) begin
            step_idx_c   = idx_q - SEL_W'(1);
            step_wraps_c = (idx_q == '0);
        end
    end

    always_comb begin
        idx_d  = idx_q;
        cnt_d  = cnt_q;
        wrap_d = 1'b0;
        d_d    = '0;
        unique case (ctrl_c)
            BLANK: begin
                d_d = '0;
            end
            DIRECT: begin
                idx_d = sel;
                cnt_d = '0;
                d_d   = OUT_W'(1) << sel;
            end
            SCAN: begin
                if (load) begin
                    idx_d = sel;
                    cnt_d = '0;
                end else if (cnt_q >= dwell) begin
                    // A counter already past a newly shortened dwell advances at once.
                    idx_d  = step_idx_c;
                    cnt_d  = '0;
                    wrap_d = step_wraps_c;
                end else begin
                    cnt_d = cnt_q + DWELL_W'(1);
                end
                d_d = OUT_W'(1) << idx_d;
            end
            default: begin
                d_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            d_q    <= '0;
            idx_q  <= '0;
            cnt_q  <= '0;
            wrap_q <= 1'b0;
        end else begin
            d_q    <= d_d;
            idx_q  <= idx_d;
            cnt_q  <= cnt_d;
            wrap_q <= wrap_d;
        end
    end

    assign d    = d_q;
    assign idx  = idx_q;
    assign wrap = wrap_q;

endmodule

// File: tb/tb_decoder_scan.sv
// Directed self-checking bench for decoder_scan (SEL_W=3, DWELL_W=4).
module tb_decoder_scan;

    logic       clk;
    logic       rst;
    logic       e;
    logic       mode;
    logic [2:0] sel;
    logic       load;
    logic [3:0] dwell;
`ifdef DECODER_SCAN_DIR_EN
    logic       dir;
`endif
    logic [7:0] d;
    logic [2:0] idx;
    logic       wrap;

    int checks   = 0;
    int failures = 0;

    decoder_scan #(.SEL_W(3), .DWELL_W(4)) dut (
        .clk  (clk),
        .rst  (rst),
        .e    (e),
        .mode (mode),
        .sel  (sel),
        .load (load),
        .dwell(dwell),
`ifdef DECODER_SCAN_DIR_EN
        .dir  (dir),
`endif
        .d    (d),
        .idx  (idx),
        .wrap (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic [7:0] ed, input logic [2:0] ei, input logic ew);
        check({tag, ".d"}, 64'(d), 64'(ed));
        check({tag, ".idx"}, 64'(idx), 64'(ei));
        check({tag, ".wrap"}, 64'(wrap), 64'(ew));
    endtask

    initial begin
        rst = 1'b1; e = 1'b0; mode = 1'b0; sel = 3'd0; load = 1'b0; dwell = 4'd0;
`ifdef DECODER_SCAN_DIR_EN
        dir = 1'b0;
`endif
        step();
        check_out("reset", 8'h00, 3'd0, 1'b0);

        // Direct decode
        rst = 1'b0; e = 1'b1; mode = 1'b0; sel = 3'd5;
        step();
        check_out("direct5", 8'h20, 3'd5, 1'b0);

        // Scan with dwell=0 walks every cycle, wrapping once
        sel = 3'd0;
        step();
        check_out("direct0", 8'h01, 3'd0, 1'b0);
        mode = 1'b1; dwell = 4'd0;
        for (int k = 1; k <= 8; k++) begin
            step();
            check_out($sformatf("scan0_%0d", k), 8'(1 << (k % 8)), 3'(k % 8), (k == 8));
        end

        // Scan with dwell=2: each index held 3 cycles
        dwell = 4'd2;
        for (int i = 0; i < 6; i++) begin
            step();
            check_out($sformatf("dwell2_%0d", i), 8'(1 << ((i + 1) / 3)), 3'((i + 1) / 3), 1'b0);
        end
        step();
        check_out("dwell2_6", 8'h04, 3'd2, 1'b0);

        // Blanking freezes idx and the hold count
        e = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check_out($sformatf("blank_%0d", i), 8'h00, 3'd2, 1'b0);
        end
        e = 1'b1;
        step();
        check_out("resume_hold", 8'h04, 3'd2, 1'b0);
        step();
        check_out("resume_adv", 8'h08, 3'd3, 1'b0);

        // Load has priority over a wrapping advance
        mode = 1'b0; sel = 3'd7;
        step();
        check_out("direct7", 8'h80, 3'd7, 1'b0);
        mode = 1'b1; dwell = 4'd0; load = 1'b1; sel = 3'd3;
        step();
        check_out("load3", 8'h08, 3'd3, 1'b0);

        // Load ignored while blanked
        e = 1'b0; sel = 3'd1;
        step();
        check_out("load_blank", 8'h00, 3'd3, 1'b0);

        // Shrinking dwell below the counter forces an immediate advance
        e = 1'b1; load = 1'b0; dwell = 4'd5;
        for (int i = 0; i < 3; i++) begin
            step();
            check_out($sformatf("long_%0d", i), 8'h08, 3'd3, 1'b0);
        end
        dwell = 4'd1;
        step();
        check_out("shrink", 8'h10, 3'd4, 1'b0);

        // Reset mid-scan at idx 6, then full hold restarts at 0
        dwell = 4'd0;
        step();
        check_out("to5", 8'h20, 3'd5, 1'b0);
        step();
        check_out("to6", 8'h40, 3'd6, 1'b0);
        rst = 1'b1;
        step();
        check_out("rst_mid", 8'h00, 3'd0, 1'b0);
        rst = 1'b0; dwell = 4'd2;
        step();
        check_out("post_rst0", 8'h01, 3'd0, 1'b0);
        step();
        check_out("post_rst1", 8'h01, 3'd0, 1'b0);
        step();
        check_out("post_rst2", 8'h02, 3'd1, 1'b0);

`ifdef DECODER_SCAN_DIR_EN
        // Down-scan from 0 wraps to 7
        rst = 1'b1;
        step();
        rst = 1'b0; dwell = 4'd0; dir = 1'b1;
        step();
        check_out("down_wrap", 8'h80, 3'd7, 1'b1);
        step();
        check_out("down6", 8'h40, 3'd6, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
